// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared types for the EX-stage iterative multiply/divide unit.
//   md_op_e      - operation encoding as presented on the op port
//   md_state_e   - sequencer states of ex_muldiv_unit
//   md_is_signed - true for the two's-complement operations
//   md_is_div    - true for the divide operations
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_step.sv
// ex_div_step: one combinational restoring-division step on unsigned values.
//   rem_in  [WIDTH]  partial remainder from the previous step (always < divisor)
//   divisor [WIDTH]  unsigned divisor magnitude
//   bit_in  [1]      next dividend bit, MSB first
//   rem_out [WIDTH]  new partial remainder
//   q_bit   [1]      quotient bit produced by this step
module ex_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtraction succeeds the result is below the divisor, so the
  // modulo-2^WIDTH difference is exact.
  assign diff    = shifted[WIDTH-1:0] - divisor;
  assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU for the EX stage.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start, op    new request (op: 0=MULT 1=MULTU 2=DIV 3=DIVU), taken in IDLE/DONE
//   a, b         forwarded operands, sampled only on an accepted start
//   flush        abort; wins over start, leaves hilo untouched
//   stall        hold the upstream pipeline while busy
//   done         one-cycle pulse, hilo valid
//   hilo         {HI,LO} result, held until the next completed operation
//   div_by_zero  flagged together with done for a divide with b == 0
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] hilo,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_in;
  logic               sign_a_q, sign_b_q, dbz_q, dbz_done_q;
  logic [WIDTH-1:0]   a_q, opnd_q;
  logic [2*WIDTH-1:0] acc_q, hilo_q, step_acc, fix_res;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept, in_signed, in_div, neg_a, neg_b;
  logic               is_div_q, neg_res;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;

  // Request decode: magnitudes and signs of the incoming operands
  assign op_in     = md_op_e'(op);
  assign in_signed = md_is_signed(op_in);
  assign in_div    = md_is_div(op_in);
  assign neg_a     = in_signed & a[WIDTH-1];
  assign neg_b     = in_signed & b[WIDTH-1];
  assign mag_a     = neg_a ? -a : a;
  assign mag_b     = neg_b ? -b : b;
  assign accept    = start && !flush && ((state_q == IDLE) || (state_q == DONE));

  // acc_q layout: multiply keeps {HI accumulator, remaining multiplier bits};
  // divide keeps {partial remainder, dividend bits shifting out / quotient in}.
  assign is_div_q = md_is_div(op_q);
  assign neg_res  = sign_a_q ^ sign_b_q;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  ex_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc_q[2*WIDTH-1:WIDTH]),
    .divisor (opnd_q),
    .bit_in  (acc_q[WIDTH-1]),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign step_acc = is_div_q ? {rem_next, acc_q[WIDTH-2:0], q_bit}
                             : {mul_sum, acc_q[WIDTH-1:1]};

  // Sign correction applied in FIX
  always_comb begin
    fix_res = acc_q;
    if (!is_div_q) begin
      if (neg_res) fix_res = -acc_q;
    end else if (dbz_q) begin
      fix_res = {a_q, {WIDTH{1'b1}}};
    end else begin
      fix_res[WIDTH-1:0]       = neg_res  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
      fix_res[2*WIDTH-1:WIDTH] = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end
  end

  // Sequencer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = accept ? CALC : IDLE;
        stall   = accept;
      end
      CALC: begin
        if (cnt_q == CNT_W'(1)) state_d = FIX;
        stall = 1'b1;
      end
      FIX: begin
        state_d = DONE;
        stall   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      stall   = 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= MD_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dbz_q      <= 1'b0;
      dbz_done_q <= 1'b0;
      a_q        <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hilo_q     <= '0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        op_q     <= op_in;
        sign_a_q <= neg_a;
        sign_b_q <= neg_b;
        dbz_q    <= (b == '0);
        a_q      <= a;
        opnd_q   <= in_div ? mag_b : mag_a;
        acc_q    <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
        cnt_q    <= CNT_W'(WIDTH);
      end else if (state_q == CALC && !flush) begin
        acc_q <= step_acc;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == FIX && !flush) begin
        hilo_q     <= fix_res;
        dbz_done_q <= is_div_q & dbz_q;
      end
    end
  end

  assign done        = (state_q == DONE);
  assign div_by_zero = (state_q == DONE) & dbz_done_q;
  assign hilo        = hilo_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage.
- Replaces the fixed-width multi-cycle mult/div path inside the ALU.
- Executes MULT, MULTU, DIV and DIVU over WIDTH-bit operands and produces a 2*WIDTH {HI,LO} result.
- Drives the pipeline stall, emits a one-cycle done pulse, and supports flush on exception or branch kill.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
- a  in  WIDTH  multiplicand / dividend, already forwarded.
- b  in  WIDTH  multiplier / divisor, already forwarded.
- flush  in  1  abort any in-flight operation.
- stall  out  1  hold the upstream pipeline.
- done  out  1  one-cycle pulse; hilo valid.
- hilo  out  2*WIDTH  {HI,LO} result.
- div_by_zero  out  1  asserted with done when DIV/DIVU had b==0.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; stall=0, done=0, hilo=0, div_by_zero=0.
  - Counter and internal registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE:
  - If start && !flush: latch op, |a|, |b| and the operand signs (signed ops only), load counter=WIDTH, then go to CALC.
  - Otherwise go to (or stay in) IDLE.
  - DONE lasts exactly one cycle.
- CALC:
  - One radix-2 step per cycle; counter decrements.
  - At counter==1 the step completes and state goes to FIX.
  - Multiply: shift-add on unsigned magnitudes, 2*WIDTH accumulator.
  - Divide: restoring, WIDTH+1-bit partial remainder.
- FIX:
  - Apply sign correction and register hilo.
  - Go to DONE.
- Latency: start in cycle 0 gives CALC in cycles 1..WIDTH, FIX in cycle WIDTH+1, and done=1 in cycle WIDTH+2.
- stall: combinational = (start && (IDLE||DONE) && !flush) || CALC || FIX. It is 0 in the done cycle.
- done = (state==DONE). hilo holds its value until the next FIX write.
- Result rules:
  - MULT: hilo = signed a*b (full 2*WIDTH product).
  - MULTU: hilo = unsigned a*b.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
- Boundary cases:
  - Divide by zero (either divide op): LO = all ones, HI = a (raw), div_by_zero=1 in the done cycle. Full latency still applies; no early exit.
  - Signed overflow (DIV with a = -2^(WIDTH-1), b = -1): LO = -2^(WIDTH-1), HI = 0. No exception.
  - MULT with the most negative operand is computed exactly. Magnitudes are held in WIDTH bits as unsigned, so this is exact.
- flush:
  - In any state, the next state is IDLE; hilo is unchanged; no done pulse.
  - stall drops in the cycle flush is high; stall is combinationally gated by !flush.
  - flush && start in the same cycle: flush wins and start is ignored.
- Back-to-back: start in the DONE cycle is accepted and the new CALC begins the next cycle.
- Operands a/b and op are ignored except on an accepted start.

Decomposition:
- Package ex_muldiv_pkg:
  - md_op_e enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - md_state_e enum (IDLE, CALC, FIX, DONE).
  - Helper function md_is_signed(op).
- One sub-module, ex_div_step: combinational restoring step.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
  - The multiply step stays inline.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> done at cycle 34 after start, hilo=0xFFFFFFFF_FFFFFFFA; stall high cycles 0..33.
- DIVU a=100, b=7 -> LO=14, HI=2; DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x00001234, div_by_zero=1 with done.
- MULTU 0xFFFFFFFF*0xFFFFFFFF started, flush at cycle 10 -> no done, stall 0 in the flush cycle, hilo keeps its previous value; new start next cycle completes normally.
- Back-to-back: second start in the done cycle is accepted; rst pulsed low mid-CALC -> immediate IDLE, all outputs 0. Repeat the divide tests with WIDTH=8 (latency 10).
